// File: rtl/ro_fifo_register_if.sv
// Processor read port and I/O push port of the buffered read-only register.
// master = processor + I/O logic side, slave = the register block.
interface ro_fifo_register_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Sys_RdEn;
  logic                  Sys_RegSelect;
  logic                  Sys_StatSelect;
  logic [DATA_WIDTH-1:0] Sys_RdData;
  logic [DATA_WIDTH-1:0] IO_WrData;
  logic                  IO_WrEn;
  logic                  IO_Busy;
  logic                  IO_Overflow;

  modport master (
    output Sys_RdEn, Sys_RegSelect, Sys_StatSelect, IO_WrData, IO_WrEn,
    input  Sys_RdData, IO_Busy, IO_Overflow
  );

  modport slave (
    input  Sys_RdEn, Sys_RegSelect, Sys_StatSelect, IO_WrData, IO_WrEn,
    output Sys_RdData, IO_Busy, IO_Overflow
  );
endinterface

// File: rtl/ro_fifo_register.sv
// Read-only peripheral register backed by a FIFO: I/O logic pushes words,
// each processor data read pops one, a status read reports fill level and overflow.
module ro_fifo_register #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 8,
  parameter bit                    OVERWRITE   = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                Clock,
  input logic                Reset,
  ro_fifo_register_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  logic                  data_rd_s;
  logic                  stat_rd_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  wr_s;
  logic                  inc_s;
  logic                  rd_adv_s;
  logic                  ovf_set_s;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_nxt_s;

  function automatic logic [DATA_WIDTH-1:0] status_word(
    input logic [CNT_W-1:0] cnt,
    input logic             empty,
    input logic             full,
    input logic             ovf
  );
    logic [DATA_WIDTH-1:0] w;
    w              = {DATA_WIDTH{1'b0}};
    w[CNT_W+7:8]   = cnt;
    w[2:0]         = {ovf, full, empty};
    return w;
  endfunction

  // Access decode and push/pop qualification; full/empty come from the count alone.
  always_comb begin
    data_rd_s = bus.Sys_RdEn & bus.Sys_RegSelect;
    stat_rd_s = bus.Sys_RdEn & bus.Sys_StatSelect & ~bus.Sys_RegSelect;
    empty_s   = (count_r == CNT_ZERO);
    full_s    = (count_r == CNT_FULL);
    pop_s     = data_rd_s & ~empty_s;
    // A pop on the same edge frees a slot, so a push into a full FIFO is then accepted.
    inc_s     = bus.IO_WrEn & (~full_s | pop_s);
    wr_s      = bus.IO_WrEn & (~full_s | pop_s | OVERWRITE);
    ovf_set_s = bus.IO_WrEn & full_s & ~pop_s;
    rd_adv_s  = pop_s | (ovf_set_s & OVERWRITE);
  end

  // Next count and next read-data value.
  always_comb begin
    count_nxt_s = count_r + (inc_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    if (pop_s) begin
      rd_data_nxt_s = mem_r[rd_ptr_r];
    end else if (stat_rd_s) begin
      rd_data_nxt_s = status_word(count_r, empty_s, full_s, ovf_r);
    end else begin
      rd_data_nxt_s = rd_data_r;
    end
  end

  // Control state: pointers, count, sticky overflow, busy and read data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= CNT_ZERO;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      rd_data_r <= RESET_VALUE;
    end else begin
      count_r   <= count_nxt_s;
      busy_r    <= (count_nxt_s == CNT_FULL);
      rd_data_r <= rd_data_nxt_s;
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // A new overflow beats the clear from a same-edge status read.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (stat_rd_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FIFO storage, deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (wr_s & ~Reset) begin
      mem_r[wr_ptr_r] <= bus.IO_WrData;
    end
  end

  assign bus.Sys_RdData  = rd_data_r;
  assign bus.IO_Busy     = busy_r;
  assign bus.IO_Overflow = ovf_r;
endmodule

// File: tb/tb_ro_fifo_register.sv
// Self-checking bench: a drop-mode and an overwrite-mode instance driven in
// lockstep and compared against a queue-based reference model.
module tb_ro_fifo_register;
  logic Clock;
  logic Reset;

  ro_fifo_register_if #(.DATA_WIDTH(32)) bus0 ();
  ro_fifo_register_if #(.DATA_WIDTH(32)) bus1 ();

  ro_fifo_register #(.DATA_WIDTH(32), .DEPTH(8), .OVERWRITE(1'b0), .RESET_VALUE(32'h0000_CAFE))
    u_dut0 (.Clock(Clock), .Reset(Reset), .bus(bus0));
  ro_fifo_register #(.DATA_WIDTH(32), .DEPTH(8), .OVERWRITE(1'b1), .RESET_VALUE(32'h0000_0000))
    u_dut1 (.Clock(Clock), .Reset(Reset), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_rd [2];
  logic        exp_ovf [2];
  logic [31:0] rst_val [2];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int qsz(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int m, input logic [31:0] d);
    if (m == 0) q0.push_back(d);
    else        q1.push_back(d);
  endtask

  task automatic qpop(input int m, output logic [31:0] d);
    if (m == 0) d = q0.pop_front();
    else        d = q1.pop_front();
  endtask

  function automatic logic [31:0] dut_rd(input int m);
    return (m == 0) ? bus0.Sys_RdData : bus1.Sys_RdData;
  endfunction
  function automatic logic dut_busy(input int m);
    return (m == 0) ? bus0.IO_Busy : bus1.IO_Busy;
  endfunction
  function automatic logic dut_ovf(input int m);
    return (m == 0) ? bus0.IO_Overflow : bus1.IO_Overflow;
  endfunction

  // Reference behaviour of one instance for one clock edge (m==1: overwrite mode).
  task automatic model_step(input int m, input logic wr, input logic [31:0] wd,
                            input logic rd, input logic rs, input logic ss, input logic rst);
    int          sz;
    logic [31:0] st;
    logic [31:0] d;
    logic        data_rd, stat_rd, set;
    if (rst) begin
      if (m == 0) q0.delete(); else q1.delete();
      exp_ovf[m] = 1'b0;
      exp_rd[m]  = rst_val[m];
    end else begin
      data_rd = rd & rs;
      stat_rd = rd & ss & ~rs;
      sz  = qsz(m);
      st  = (sz * 256) + (exp_ovf[m] ? 4 : 0) + ((sz == 8) ? 2 : 0) + ((sz == 0) ? 1 : 0);
      set = 1'b0;
      if (data_rd) begin
        if (sz > 0) begin
          qpop(m, d);
          exp_rd[m] = d;
        end
      end else if (stat_rd) begin
        exp_rd[m] = st;
      end
      if (wr) begin
        if (qsz(m) < 8) qpush(m, wd);
        else begin
          set = 1'b1;
          if (m == 1) begin
            qpop(m, d);
            qpush(m, wd);
          end
        end
      end
      if (stat_rd) exp_ovf[m] = 1'b0;
      if (set)     exp_ovf[m] = 1'b1;
    end
  endtask

  task automatic step(input logic wr, input logic [31:0] wd, input logic rd,
                      input logic rs, input logic ss, input logic rst);
    Reset = rst;
    bus0.IO_WrEn = wr; bus0.IO_WrData = wd; bus0.Sys_RdEn = rd;
    bus0.Sys_RegSelect = rs; bus0.Sys_StatSelect = ss;
    bus1.IO_WrEn = wr; bus1.IO_WrData = wd; bus1.Sys_RdEn = rd;
    bus1.Sys_RegSelect = rs; bus1.Sys_StatSelect = ss;
    @(posedge Clock);
    for (int m = 0; m < 2; m++) model_step(m, wr, wd, rd, rs, ss, rst);
    #1;
    Reset = 1'b0;
    bus0.IO_WrEn = 1'b0; bus0.Sys_RdEn = 1'b0;
    bus1.IO_WrEn = 1'b0; bus1.Sys_RdEn = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== rst_val[m]) begin
        bad++; $display("FAIL reset_rddata[%0d] got=%h want=%h", m, dut_rd(m), rst_val[m]);
      end
      total++;
      if (dut_busy(m) !== 1'b0 || dut_ovf(m) !== 1'b0) begin
        bad++; $display("FAIL reset_flags[%0d] got busy=%b ovf=%b want 0 0", m, dut_busy(m), dut_ovf(m));
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== 32'h0000_0001) begin
        bad++; $display("FAIL reset_status[%0d] got=%h want=%h", m, dut_rd(m), 32'h0000_0001);
      end
    end
  endtask

  task automatic test_order;
    logic [31:0] want [4];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h33;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_rd(m) !== want[i]) begin
          bad++; $display("FAIL order_read%0d[%0d] got=%h want=%h", i, m, dut_rd(m), want[i]);
        end
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== 32'h0000_0001) begin
        bad++; $display("FAIL order_status[%0d] got=%h want=%h", m, dut_rd(m), 32'h0000_0001);
      end
    end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] w;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 6 || i == 7) begin
        for (int m = 0; m < 2; m++) begin
          total++;
          if (dut_busy(m) !== (i == 7)) begin
            bad++; $display("FAIL fill_busy%0d[%0d] got=%b want=%b", i, m, dut_busy(m), (i == 7));
          end
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_ovf(m) !== 1'b1) begin
        bad++; $display("FAIL fill_ovf[%0d] got=%b want=1", m, dut_ovf(m));
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== 32'h0000_0806) begin
        bad++; $display("FAIL fill_status[%0d] got=%h want=%h", m, dut_rd(m), 32'h0000_0806);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        w = (m == 0) ? i : i + 2;
        total++;
        if (dut_rd(m) !== w) begin
          bad++; $display("FAIL fill_read%0d[%0d] got=%h want=%h", i, m, dut_rd(m), w);
        end
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== 32'h0000_0001 || dut_ovf(m) !== 1'b0) begin
        bad++; $display("FAIL drain_status[%0d] got=%h ovf=%b want=%h ovf=0", m, dut_rd(m), dut_ovf(m), 32'h0000_0001);
      end
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] first;
    logic [31:0] w;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    first = $urandom;
    step(1'b1, first, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00AA, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== first) begin
        bad++; $display("FAIL fullpp_oldest[%0d] got=%h want=%h", m, dut_rd(m), first);
      end
      total++;
      if (dut_busy(m) !== 1'b1 || dut_ovf(m) !== 1'b0) begin
        bad++; $display("FAIL fullpp_flags[%0d] got busy=%b ovf=%b want 1 0", m, dut_busy(m), dut_ovf(m));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_rd(m) !== exp_rd[m]) begin
          bad++; $display("FAIL fullpp_drain%0d[%0d] got=%h want=%h", i, m, dut_rd(m), exp_rd[m]);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      w = dut_rd(m);
      total++;
      if (w !== 32'h0000_00AA) begin
        bad++; $display("FAIL fullpp_last[%0d] got=%h want=%h", m, w, 32'h0000_00AA);
      end
    end
  endtask

  task automatic test_stat_ovf_same_edge;
    logic [31:0] w;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      w = dut_rd(m);
      total++;
      if (w[2] !== 1'b0 || w !== exp_rd[m]) begin
        bad++; $display("FAIL statovf_word[%0d] got=%h want=%h", m, w, exp_rd[m]);
      end
      total++;
      if (dut_ovf(m) !== 1'b1) begin
        bad++; $display("FAIL statovf_flag[%0d] got=%b want=1", m, dut_ovf(m));
      end
    end
    // Burst with overflow pending, then reset while push and read are both asserted.
    step(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0088, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (dut_rd(m) !== rst_val[m] || dut_busy(m) !== 1'b0 || dut_ovf(m) !== 1'b0) begin
        bad++; $display("FAIL midreset[%0d] got rd=%h busy=%b ovf=%b want rd=%h busy=0 ovf=0",
                        m, dut_rd(m), dut_busy(m), dut_ovf(m), rst_val[m]);
      end
    end
  endtask

  task automatic test_random;
    logic wr, rd, rs, ss, rst;
    for (int i = 0; i < 600; i++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      rs  = ($urandom_range(0, 99) < 60);
      ss  = ($urandom_range(0, 99) < 50);
      rst = ($urandom_range(0, 199) == 0);
      step(wr, $urandom, rd, rs, ss, rst);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (dut_rd(m) !== exp_rd[m] || dut_busy(m) !== (qsz(m) == 8) || dut_ovf(m) !== exp_ovf[m]) begin
          bad++; $display("FAIL random%0d[%0d] got rd=%h busy=%b ovf=%b want rd=%h busy=%b ovf=%b",
                          i, m, dut_rd(m), dut_busy(m), dut_ovf(m), exp_rd[m], (qsz(m) == 8), exp_ovf[m]);
        end
      end
    end
  endtask

  initial begin
    rst_val[0] = 32'h0000_CAFE;
    rst_val[1] = 32'h0000_0000;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0;
    Reset = 1'b1;
    bus0.IO_WrEn = 1'b0; bus0.IO_WrData = 32'h0; bus0.Sys_RdEn = 1'b0;
    bus0.Sys_RegSelect = 1'b0; bus0.Sys_StatSelect = 1'b0;
    bus1.IO_WrEn = 1'b0; bus1.IO_WrData = 32'h0; bus1.Sys_RdEn = 1'b0;
    bus1.Sys_RegSelect = 1'b0; bus1.Sys_StatSelect = 1'b0;
    @(posedge Clock);
    #1;
    test_reset;
    test_order;
    test_fill_overflow;
    test_full_push_pop;
    test_stat_ovf_same_edge;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
